// File: rtl/calc_bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the calculator BCD display path.
package calc_bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest number of decimal digits that can hold 2^width - 1.
    function automatic int min_digits(input int width);
        longint unsigned lim;
        int d;
        lim = (longint'(1) << width) - 1;
        d = 1;
        while (lim >= 10) begin
            lim = lim / 10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
    import calc_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes, one bit per clock.
// Optional BIN_TO_BCD_SIGNED_EN: two's complement input, magnitude converted and sign on neg.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready=1
// SHIFT | one correct-and-shift iteration per clock, busy=1
// DONE  | bcd_out holds the result, out_valid=1 until out_ready
module bin_to_bcd_seq
    import calc_bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef BIN_TO_BCD_SIGNED_EN
    output logic                  neg,
`endif
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small to represent 2^WIDTH-1");
    end

    state_t               state, state_nx;
    logic                 accept, last;
    logic [WIDTH-1:0]     bin_sr;
    logic [SCR_W-1:0]     scratch;
    logic [SCR_W-1:0]     corrected;
    logic [SCR_W+WIDTH-1:0] shift_nx;
    logic [CNT_W-1:0]     count;
    logic [SCR_W-1:0]     bcd_r;
    logic [WIDTH-1:0]     load_val;
    logic                 load_neg;

    // -------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == LAST_CNT) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------
    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (corrected[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shift_nx = {corrected, bin_sr} << 1;

`ifdef BIN_TO_BCD_SIGNED_EN
    // Negating the most negative value wraps to itself, which read unsigned is its magnitude.
    assign load_neg = bin_in[WIDTH-1];
    assign load_val = load_neg ? (~bin_in + WIDTH'(1)) : bin_in;
`else
    assign load_neg = 1'b0;
    assign load_val = bin_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            scratch <= '0;
            count   <= '0;
            bcd_r   <= '0;
        end else if (accept) begin
            bin_sr  <= load_val;
            scratch <= '0;
            count   <= '0;
        end else if (state == SHIFT) begin
            scratch <= shift_nx[SCR_W+WIDTH-1:WIDTH];
            bin_sr  <= shift_nx[WIDTH-1:0];
            count   <= count + CNT_W'(1);
            if (last) begin
                bcd_r <= shift_nx[SCR_W+WIDTH-1:WIDTH];
            end
        end
    end

    assign bcd_out = bcd_r;

`ifdef BIN_TO_BCD_SIGNED_EN
    logic sign_r;
    logic neg_r;

    // Sign is published together with bcd_out so neg never changes under a held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            sign_r <= load_neg;
        end else if (last) begin
            neg_r  <= sign_r;
        end
    end

    assign neg = neg_r;
`else
    logic unused_load_neg;
    assign unused_load_neg = load_neg;
`endif

endmodule
